conv2d_stream: RTL and testbench

- Parametrised streaming 2-D convolution (correlation, no kernel flip) of an N x N image with a K x K kernel.
- Successor to the fixed 3x3/2x2 unsigned convolver, adding:
  - signed arithmetic with saturation
  - valid/ready handshakes on input and output, with backpressure
  - optional kernel retention across frames
- Sits between the pixel source and the result sink in the convolution datapath.
- Coefficients and pixels share one input stream.

---
 rtl/conv2d_stream.sv | 244 ++++++++++++++++++++++++
 tb/tb_conv2d_stream.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream.sv
// -----------------------------------------------------------------------------
// conv2d_stream
//   Streaming 2-D correlation of an N x N signed image with a K x K signed
//   kernel. Coefficients and pixels share one valid/ready input stream: each
//   frame starts with K*K coefficients (row-major), unless the previous frame
//   asked to retain them. Then N*N pixels follow, row-major. One registered,
//   saturated result is produced per valid window position, row-major. A
//   single-entry output register applies backpressure to the whole pipeline.
//
// Ports
//   clock        rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     in_data valid
//   in_ready     block accepts in_data this cycle
//   in_data      coefficient (LOAD_K) or pixel (STREAM), low bits used
//   keep_kernel  sampled with the last pixel; 1 = skip the next kernel load
//   out_valid    result valid
//   out_ready    sink accepts result
//   result       signed saturated window sum
//   out_last     marks the final result of a frame
// -----------------------------------------------------------------------------
module conv2d_stream #(
    parameter int N      = 3,
    parameter int K      = 2,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic                                             clock,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [((DATA_W > COEF_W) ? DATA_W : COEF_W)-1:0] in_data,
    input  logic                                             keep_kernel,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [OUT_W-1:0]                                 result,
    output logic                                             out_last
);

    localparam int KK     = K * K;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(KK);
    // Pixel history needed to reach the oldest tap of the window.
    localparam int SR_LEN = (K - 1) * N + K - 1;
    localparam int SR_D   = (SR_LEN > 0) ? SR_LEN : 1;
    localparam int CW     = $clog2(N + 1);
    localparam int KW     = (KK > 1) ? $clog2(KK) : 1;

    typedef enum logic {
        LOAD_K,
        STREAM
    } state_t;

    state_t state;
    state_t state_next;

    logic [KW-1:0] kcnt;
    logic [CW-1:0] row;
    logic [CW-1:0] col;

    logic signed [COEF_W-1:0] coef [KK];
    logic signed [DATA_W-1:0] sr   [SR_D];

    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] tap;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  sat;

    logic accept;
    logic k_accept;
    logic p_accept;
    logic k_done;
    logic last_pix;
    logic win_ok;
    logic unused_in_bits;

    assign pix            = in_data[DATA_W-1:0];
    assign unused_in_bits = ^in_data;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    assign in_ready = (state == LOAD_K) ? 1'b1 : (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign k_accept = accept && (state == LOAD_K);
    assign p_accept = accept && (state == STREAM);

    assign k_done   = (kcnt == KW'(KK - 1));
    assign last_pix = (row == CW'(N - 1)) && (col == CW'(N - 1));
    assign win_ok   = (row >= CW'(K - 1)) && (col >= CW'(K - 1));

    // ---------------------------------------------------------------------
    // State machine
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= LOAD_K;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD_K: begin
                if (k_accept && k_done) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (p_accept && last_pix && !keep_kernel) begin
                    state_next = LOAD_K;
                end
            end
            default: state_next = LOAD_K;
        endcase
    end

    // ---------------------------------------------------------------------
    // Coefficient index and pixel row/column counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            kcnt <= '0;
            row  <= '0;
            col  <= '0;
        end else begin
            if (k_accept) begin
                kcnt <= k_done ? '0 : kcnt + 1'b1;
                if (k_done) begin
                    row <= '0;
                    col <= '0;
                end
            end
            // Wrapping to 0 on the last pixel lets a retained-kernel frame
            // start on the very next accept.
            if (p_accept) begin
                if (col == CW'(N - 1)) begin
                    col <= '0;
                    row <= (row == CW'(N - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Coefficient registers (retained across frames)
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (k_accept) begin
            coef[kcnt] <= in_data[COEF_W-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Pixel history: sr[0] is the previous pixel, sr[d-1] is d pixels back.
    // The K-1 line buffers and the window are all slices of this one chain.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (p_accept) begin
            sr[0] <= pix;
            for (int unsigned i = 1; i < SR_D; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Distance back in the pixel stream from the incoming pixel
    // x[i+K-1][j+K-1] to the tap x[i+r][j+c].
    function automatic int unsigned tap_ofs(input int unsigned r, input int unsigned c);
        return (K - 1 - r) * N + (K - 1 - c);
    endfunction

    // The window sum is formed from the incoming pixel plus history, so the
    // result can be registered on the same edge the last window pixel lands.
    always_comb begin
        acc  = '0;
        tap  = '0;
        prod = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                if (tap_ofs(r, c) == 0) begin
                    tap = pix;
                end else begin
                    tap = sr[tap_ofs(r, c) - 1];
                end
                prod = PROD_W'(tap) * PROD_W'(coef[r*K + c]);
                acc  = acc + ACC_W'(prod);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Saturation to OUT_W
    // ---------------------------------------------------------------------
    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign sat = OUT_W'(acc);
        end else begin : g_sat
            localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
            localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
            logic [ACC_W-OUT_W:0] upper;

            // The value fits when every bit from the output sign bit upward
            // agrees; otherwise the accumulator sign picks the clamp.
            assign upper = acc[ACC_W-1:OUT_W-1];

            always_comb begin
                if ((upper == '0) || (upper == '1)) begin
                    sat = acc[OUT_W-1:0];
                end else if (acc[ACC_W-1]) begin
                    sat = SAT_MIN;
                end else begin
                    sat = SAT_MAX;
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Output register. A producing accept can only happen when the register
    // is empty or being drained this cycle, so a held result is never lost.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_last  <= 1'b0;
        end else if (p_accept && win_ok) begin
            out_valid <= 1'b1;
            result    <= sat;
            out_last  <= last_pix;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// -----------------------------------------------------------------------------
// tb_conv2d_stream
//   Two instances: A (N=3, K=2, 8-bit data/coef, 16-bit out) for the directed
//   small-kernel, backpressure, saturation and reset cases; B (N=5, K=3,
//   default widths) for identity-kernel retention and random traffic.
//   Expected results are queued when a frame is issued; per-instance monitors
//   pop and compare on every output handshake.
// -----------------------------------------------------------------------------
module tb_conv2d_stream;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst;

    logic        a_in_valid, a_in_ready, a_keep, a_out_valid, a_out_ready, a_out_last;
    logic [7:0]  a_in_data;
    logic [15:0] a_result;

    logic        b_in_valid, b_in_ready, b_keep, b_out_valid, b_out_ready, b_out_last;
    logic [15:0] b_in_data;
    logic [31:0] b_result;
    bit          b_rmode;

    conv2d_stream #(.N(3), .K(2), .DATA_W(8), .COEF_W(8), .OUT_W(16)) u_a (
        .clock(clock), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .keep_kernel(a_keep),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .result(a_result), .out_last(a_out_last)
    );

    conv2d_stream #(.N(5), .K(3), .DATA_W(16), .COEF_W(16), .OUT_W(32)) u_b (
        .clock(clock), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .keep_kernel(b_keep),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result), .out_last(b_out_last)
    );

    typedef struct {
        longint v;
        bit     last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_a(input longint v, input bit last);
        exp_t e;
        e.v = v;
        e.last = last;
        qa.push_back(e);
    endtask

    task automatic push_b(input longint v, input bit last);
        exp_t e;
        e.v = v;
        e.last = last;
        qb.push_back(e);
    endtask

    // Monitors: out_ready is driven just after posedge, so at negedge these
    // values are the ones the next edge will see.
    always @(negedge clock) begin
        exp_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected: got %0d expected no output", $signed(a_result));
            end else begin
                e = qa.pop_front();
                check("a_result", longint'($signed(a_result)), e.v);
                check("a_last", longint'(a_out_last), longint'(e.last));
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: got %0d expected no output", $signed(b_result));
            end else begin
                e = qb.pop_front();
                check("b_result", longint'($signed(b_result)), e.v);
                check("b_last", longint'(b_out_last), longint'(e.last));
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (b_rmode) b_out_ready = 1'($urandom_range(0, 1));
    end

    // Drivers: called just after a posedge, return just after the accept edge.
    task automatic send_a(input logic [7:0] d, input logic keep);
        int  n = 0;
        bit  done = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_keep     = keep;
        while (!done) begin
            @(negedge clock);
            if (a_in_ready) done = 1;
            @(posedge clock);
            #1;
            n++;
            if (!done && n > 200) begin
                tests++;
                fails++;
                $display("FAIL a_accept_timeout: got no accept expected accept within 200 cycles");
                done = 1;
            end
        end
        a_in_valid = 1'b0;
        a_keep     = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic keep, input bit gaps);
        int  n = 0;
        bit  done = 0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            @(posedge clock);
            #1;
        end
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_keep     = keep;
        while (!done) begin
            @(negedge clock);
            if (b_in_ready) done = 1;
            @(posedge clock);
            #1;
            n++;
            if (!done && n > 200) begin
                tests++;
                fails++;
                $display("FAIL b_accept_timeout: got no accept expected accept within 200 cycles");
                done = 1;
            end
        end
        b_in_valid = 1'b0;
        b_keep     = 1'b0;
    endtask

    task automatic frame_a(input bit load, input int c[4], input int x[9], input bit keep);
        if (load) for (int i = 0; i < 4; i++) send_a(8'(c[i]), 1'b0);
        for (int i = 0; i < 9; i++) send_a(8'(x[i]), (i == 8) ? keep : 1'b0);
    endtask

    task automatic frame_b(input bit load, input int c[9], input int x[25], input bit keep,
                           input bit gaps);
        if (load) for (int i = 0; i < 9; i++) send_b(16'(c[i]), 1'b0, gaps);
        for (int i = 0; i < 25; i++) send_b(16'(x[i]), (i == 24) ? keep : 1'b0, gaps);
    endtask

    // Reference for instance B: 3x3 correlation over a 5x5 frame, 32-bit clamp.
    task automatic model_b(input int c[9], input int x[25]);
        longint s;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int r = 0; r < 3; r++)
                    for (int cc = 0; cc < 3; cc++)
                        s += longint'(x[(i + r) * 5 + j + cc]) * longint'(c[r * 3 + cc]);
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
                push_b(s, (i == 2) && (j == 2));
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        check("drain_a", longint'(qa.size()), 0);
        check("drain_b", longint'(qb.size()), 0);
    endtask

    initial begin : main
        int ac[4];
        int ax[9];
        int bc[9];
        int bx[25];
        bit keep;
        bit load;
        shortint s;

        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_keep = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_keep = 0; b_out_ready = 1; b_rmode = 0;
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;

        check("rst_a_valid", longint'(a_out_valid), 0);
        check("rst_a_result", longint'(a_result), 0);
        check("rst_a_last", longint'(a_out_last), 0);
        check("rst_a_ready", longint'(a_in_ready), 1);
        check("rst_b_valid", longint'(b_out_valid), 0);
        check("rst_b_ready", longint'(b_in_ready), 1);

        // Basic frame: kernel 1,2,3,4 over pixels 1..9.
        ac = '{1, 2, 3, 4};
        ax = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        push_a(37, 0); push_a(47, 0); push_a(67, 0); push_a(77, 1);
        frame_a(1, ac, ax, 0);
        drain();
        repeat (3) begin
            @(negedge clock);
            check("a_ready_loadk", longint'(a_in_ready), 1);
        end
        @(posedge clock);
        #1;

        // Backpressure: sink refuses the first result for several cycles.
        a_out_ready = 1'b0;
        push_a(37, 0); push_a(47, 0); push_a(67, 0); push_a(77, 1);
        fork
            frame_a(1, ac, ax, 0);
            begin
                int w;
                w = 0;
                while (!a_out_valid && w < 100) begin
                    @(negedge clock);
                    w++;
                end
                check("a_bp_seen_valid", longint'(a_out_valid), 1);
                repeat (5) begin
                    check("a_bp_hold_result", longint'($signed(a_result)), 37);
                    check("a_bp_hold_valid", longint'(a_out_valid), 1);
                    check("a_bp_in_ready", longint'(a_in_ready), 0);
                    @(negedge clock);
                end
                @(posedge clock);
                #1;
                a_out_ready = 1'b1;
            end
        join
        drain();

        // Saturation on 8/8/16 instance, kernel retained for the second frame.
        ac = '{127, 127, 127, 127};
        ax = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        repeat (3) push_a(32767, 0);
        push_a(32767, 1);
        frame_a(1, ac, ax, 1);
        ax = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        repeat (3) push_a(-32768, 0);
        push_a(-32768, 1);
        frame_a(0, ac, ax, 0);
        drain();

        // Reset after five pixels aborts the frame; a full reload follows.
        ac = '{1, 2, 3, 4};
        ax = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        for (int i = 0; i < 4; i++) send_a(8'(ac[i]), 1'b0);
        for (int i = 0; i < 5; i++) send_a(8'(ax[i]), 1'b0);
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", longint'(a_out_valid), 0);
        check("mid_rst_result", longint'(a_result), 0);
        check("mid_rst_last", longint'(a_out_last), 0);
        check("mid_rst_ready", longint'(a_in_ready), 1);
        push_a(37, 0); push_a(47, 0); push_a(67, 0); push_a(77, 1);
        frame_a(1, ac, ax, 0);
        drain();

        // Identity 3x3 kernel on N=5, then a back-to-back retained-kernel frame.
        bc = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 25; i++) bx[i] = i;
        push_b(6, 0);  push_b(7, 0);  push_b(8, 0);
        push_b(11, 0); push_b(12, 0); push_b(13, 0);
        push_b(16, 0); push_b(17, 0); push_b(18, 1);
        frame_b(1, bc, bx, 1, 0);
        for (int i = 0; i < 25; i++) bx[i] = 25 + i;
        push_b(31, 0); push_b(32, 0); push_b(33, 0);
        push_b(36, 0); push_b(37, 0); push_b(38, 0);
        push_b(41, 0); push_b(42, 0); push_b(43, 1);
        frame_b(0, bc, bx, 0, 0);
        drain();

        // Random signed traffic with random valid gaps and sink stalls.
        b_rmode = 1;
        load = 1;
        for (int f = 0; f < 100; f++) begin
            if (load) begin
                for (int i = 0; i < 9; i++) begin
                    s = shortint'($urandom);
                    bc[i] = int'(s);
                end
            end
            for (int i = 0; i < 25; i++) begin
                s = shortint'($urandom);
                bx[i] = int'(s);
            end
            keep = 1'($urandom_range(0, 1));
            model_b(bc, bx);
            frame_b(load, bc, bx, keep, 1);
            load = !keep;
        end
        drain();
        b_rmode = 0;
        b_out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
